// File: rtl/cmp_arbiter.sv
// cmp_arbiter
//   Two requesters share one subtract-and-zero-detect compare unit.
//   Each operation walks IDLE -> SUB -> CHK -> IDLE. Requester 0 is the
//   branch unit, requester 1 is the bex/setx unit. Under contention the
//   requester that was not served last wins (round-robin).
//
//   Optional feature: define CMP_LT_EN to build the overflow register and
//   the signed less-than result. Without it, lt is tied to 0.
//
// Ports
//   clock          rising-edge clock for all state
//   reset          asynchronous reset, active low
//   req[1:0]       compare requests (bit 0 branch unit, bit 1 bex/setx)
//   a0,b0 / a1,b1  32-bit operands of requester 0 / 1
//   grant[1:0]     combinational one-hot grant, only in the capture (IDLE) cycle
//   done[1:0]      registered one-hot, one-cycle result-valid pulse
//   eq             registered a==b of the last completed operation
//   lt             registered signed a<b of the last completed operation
//   busy           high in SUB and CHK
module cmp_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic        eq,
  output logic        lt,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    CHK  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Operands arranged per requester so the winner can index them.
  logic [1:0][31:0] a_in, b_in;
  assign a_in = {a1, a0};
  assign b_in = {b1, b0};

  logic        any_req;  // at least one requester is asking
  logic        win;      // index of the requester that wins this IDLE cycle
  logic        last;     // index of the requester served most recently
  logic        owner;    // requester owning the in-flight operation
  logic        capture;  // operands are latched at the coming edge
  logic [31:0] opa, opb; // captured operands
  logic [31:0] diff_c;   // combinational a - b of captured operands
  logic [31:0] diff;     // registered difference

  assign any_req = |req;
  // Single request wins outright; on contention the one not served last.
  assign win     = (req == 2'b11) ? ~last : req[1];
  assign diff_c  = opa - opb;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------
  // FSM: next state and combinational outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    grant     = 2'b00;
    busy      = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        // Gate with reset so grant drops the instant reset asserts.
        if (any_req && reset) begin
          grant     = win ? 2'b10 : 2'b01;
          capture   = 1'b1;
          state_nxt = SUB;
        end
      end
      SUB: begin
        busy      = 1'b1;
        state_nxt = CHK;
      end
      CHK: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Operand capture, ownership and round-robin pointer
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opa   <= '0;
      opb   <= '0;
      owner <= 1'b0;
      last  <= 1'b1;  // requester 0 wins the first contention
    end else if (capture) begin
      opa   <= a_in[win];
      opb   <= b_in[win];
      owner <= win;
      last  <= win;
    end
  end

  // ---------------------------------------------------------------------
  // Subtract stage and result stage
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      diff <= '0;
      eq   <= 1'b0;
      done <= 2'b00;
    end else begin
      done <= 2'b00;
      if (state == SUB) diff <= diff_c;
      if (state == CHK) begin
        eq   <= ~|diff;
        done <= owner ? 2'b10 : 2'b01;
      end
    end
  end

`ifdef CMP_LT_EN
  // Signed a<b = sign of the difference, corrected when the subtraction
  // overflowed (operand signs differ and result sign differs from a).
  logic ovf;
  logic lt_r;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf  <= 1'b0;
      lt_r <= 1'b0;
    end else begin
      if (state == SUB) ovf  <= (opa[31] ^ opb[31]) & (diff_c[31] ^ opa[31]);
      if (state == CHK) lt_r <= diff[31] ^ ovf;
    end
  end

  assign lt = lt_r;
`else
  assign lt = 1'b0;
`endif

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. The clock port SHALL be named clock and the reset port SHALL be named reset (asserted at 0).
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req  input  2  compare request; req[0] is the branch unit, req[1] is the bex/setx unit.
REQ-005 a0, b0  input  32 each  operands of requester 0.
REQ-006 a1, b1  input  32 each  operands of requester 1.
REQ-007 grant  output  2  combinational, one-hot, high only in the IDLE cycle in which the operands of that requester are captured.
REQ-008 done  output  2  registered, one-hot, one-cycle pulse marking valid results for that requester.
REQ-009 eq  output  1  registered; 1 when a==b for the last completed operation.
REQ-010 lt  output  1  registered; 1 when signed a<b for the last completed operation (only when CMP_LT_EN is defined).
REQ-011 busy  output  1  1 in SUB and CHK states.

Function
REQ-012 The block SHALL arbitrate between two requesters for a single shared subtract-and-zero-detect unit, using the FSM states IDLE -> SUB -> CHK -> IDLE.
REQ-013 In IDLE with any req bit high, the block SHALL:
- assert grant for the winner;
- capture that requester's a and b at the next rising edge;
- record the owner;
- enter SUB.
REQ-014 In IDLE with req==00, the block SHALL remain in IDLE with grant==00.
REQ-015 When exactly one req bit is high, the block SHALL grant that requester.
REQ-016 When req==11, the block SHALL grant the requester not served last (round-robin), so repeated contention alternates requesters.
REQ-017 In SUB, the block SHALL register diff = a - b (32-bit, wrap-around) and the signed overflow flag, then enter CHK.
REQ-018 In CHK, the block SHALL compute eq = (diff == 0 across all 32 bits) and lt = diff[31] XOR overflow. At the next edge it SHALL:
- register eq and lt;
- pulse done[owner] for exactly one cycle;
- return to IDLE.
REQ-019 Latency SHALL be 3 rising edges from the capture edge to done becoming high. Throughput SHALL be at most one operation per 3 cycles.
REQ-020 The arbiter SHALL accept a new request in the same cycle that done is high, because that cycle is an IDLE cycle.
REQ-021 A requester SHALL hold req high until its grant. A requester that still holds req in its done cycle SHALL be treated as a new request.
REQ-022 req changes during SUB or CHK SHALL be ignored, and operand changes after capture SHALL NOT affect the result.
REQ-023 eq and lt SHALL hold their value between done pulses.
REQ-024 Boundary values SHALL produce:
- a=0x80000000, b=0x00000001: lt=1, eq=0 (overflow-corrected);
- a=b=0xFFFFFFFF: eq=1, lt=0.

Reset
REQ-025 reset low SHALL immediately force:
- state=IDLE;
- grant=00, done=00;
- eq=0, lt=0, busy=0;
- the round-robin pointer = "requester 1 served last", so requester 0 wins the first contention.
REQ-026 Reset asserted during SUB or CHK SHALL abort the operation with no done pulse. After release, the block SHALL restart from IDLE.
REQ-027 Reset release SHALL take effect at the first rising edge after reset goes high, with no spurious grant or done.

Configuration
REQ-028 Macro CMP_LT_EN defined: the block SHALL include the overflow register and signed less-than logic, and lt SHALL behave per REQ-018.
REQ-029 Macro CMP_LT_EN undefined: the block SHALL omit the overflow and lt logic, tie lt to 0, and leave eq, timing and arbitration unchanged.

Verification
REQ-030 Single request, equal operands: req=01, a0=b0=0x12345678 -> grant=01 in the capture cycle; 3 edges later done=01, eq=1, lt=0.
REQ-031 Contention after reset: req=11, a0=5, b0=7, a1=9, b1=9 -> first done=01 with eq=0 and lt=1 (lt=0 without CMP_LT_EN); then done=10 with eq=1.
REQ-032 Overflow check: a1=0x80000000, b1=0x00000001 -> done=10, eq=0, lt=1; then a1=0x7FFFFFFF, b1=0xFFFFFFFF -> lt=0.
REQ-033 Reset mid-operation: reset=0 during SUB -> no done pulse; grant=00, busy=0 and eq=lt=0 immediately.
REQ-034 Back-to-back operations: req=01 held continuously -> done=01 every 3 cycles; a0 changed during SUB does not affect the in-flight result.
